// File: rtl/a0_change_fifo.sv
// a0_change_fifo: captures each change of the CPU a0 value into a first-word fall-through FIFO
module a0_change_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       en_i,
    input  logic                       ready_i,
    input  logic                       ovf_clr_i,
    output logic [DW-1:0]              data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] prev_q;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          change, pop, push, drop, full;

    assign full       = cnt_q == FULL;
    assign valid_o    = cnt_q != '0;
    assign data_o     = mem_q[rd_q];
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

    // Classify the cycle; a pop on a full FIFO frees the slot the push reuses
    always_comb begin
        change = en_i && (data_i != prev_q);
        pop    = valid_o && ready_i;
        push   = change && (!full || pop);
        drop   = change && full && !pop;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        cnt_d  = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
        ovf_d  = drop || (ovf_q && !ovf_clr_i);
    end

    // Control state and the previous-sample register, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= data_i;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: tb/tb_a0_change_fifo.sv
// tb_a0_change_fifo: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_a0_change_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = '0;
    logic       en = 1'b0;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [3:0] count_o;
    logic       overflow_o;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    a0_change_fifo #(.DW(8), .DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .en_i(en), .ready_i(ready),
        .ovf_clr_i(clr), .data_o(data_o), .valid_o(valid_o), .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic e, input logic r, input logic c);
        data = d;
        en = e;
        ready = r;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must deliver the oldest expected entry
    always @(negedge clk) begin
        if (!rst && valid_o && ready) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("pop_data", data_o, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst = 1'b0;
        // zero held after reset is never a change
        for (int i = 0; i < 5; i++) step(8'h00, 1, 0, 0);
        chk("zero_count", count_o, 0);
        chk("zero_valid", valid_o, 0);
        // repeated values collapse to one entry each
        exp_q.push_back(8'h05); exp_q.push_back(8'h09); exp_q.push_back(8'h02);
        step(8'h05, 1, 0, 0); step(8'h05, 1, 0, 0); step(8'h09, 1, 0, 0);
        step(8'h09, 1, 0, 0); step(8'h02, 1, 0, 0);
        chk("seq_count", count_o, 3);
        chk("seq_head_hold", data_o, 8'h05);
        for (int i = 0; i < 4; i++) step(8'h02, 1, 1, 0);
        chk("seq_valid_end", valid_o, 0);
        chk("seq_sb_empty", exp_q.size(), 0);
        // overflow: ten distinct values into eight slots
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 10; i++) step(8'(i), 1, 0, 0);
        chk("ovf_count", count_o, 8);
        chk("ovf_flag", overflow_o, 1);
        for (int i = 0; i < 9; i++) step(8'h0A, 1, 1, 0);
        chk("ovf_drain_count", count_o, 0);
        chk("ovf_sticky", overflow_o, 1);
        chk("ovf_sb_empty", exp_q.size(), 0);
        step(8'h0A, 1, 0, 1);
        chk("ovf_cleared", overflow_o, 0);
        // full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h21 + 8'(i));
            step(8'h21 + 8'(i), 1, 0, 0);
        end
        chk("full_count", count_o, 8);
        exp_q.push_back(8'h7F);
        step(8'h7F, 1, 1, 0);
        chk("full_pp_count", count_o, 8);
        chk("full_pp_ovf", overflow_o, 0);
        for (int i = 0; i < 9; i++) step(8'h7F, 1, 1, 0);
        chk("full_pp_drain", count_o, 0);
        chk("full_pp_sb_empty", exp_q.size(), 0);
        // drop and clear on the same edge: set wins
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h31 + 8'(i));
            step(8'h31 + 8'(i), 1, 0, 0);
        end
        step(8'h39, 1, 0, 1);
        chk("setwins_ovf", overflow_o, 1);
        chk("setwins_count", count_o, 8);
        step(8'h39, 1, 0, 1);
        chk("clr_only_ovf", overflow_o, 0);
        for (int i = 0; i < 9; i++) step(8'h39, 1, 1, 0);
        chk("setwins_sb_empty", exp_q.size(), 0);
        // single entry replaced in one edge
        exp_q.push_back(8'h40); exp_q.push_back(8'h41);
        step(8'h40, 1, 0, 0);
        chk("one_count", count_o, 1);
        step(8'h41, 1, 1, 0);
        chk("one_pp_count", count_o, 1);
        chk("one_pp_head", data_o, 8'h41);
        step(8'h41, 1, 1, 0);
        chk("one_pp_valid", valid_o, 0);
        // disabled changes are not captured, nor is the value held afterwards
        step(8'h11, 0, 0, 0); step(8'h22, 0, 0, 0);
        step(8'h22, 1, 0, 0); step(8'h22, 1, 0, 0);
        chk("en_off_count", count_o, 0);
        // asynchronous reset mid-operation
        step(8'h51, 1, 0, 0); step(8'h52, 1, 0, 0); step(8'h53, 1, 0, 0);
        chk("prerst_count", count_o, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", valid_o, 0);
        chk("async_rst_count", count_o, 0);
        #2 rst = 1'b0;
        step(8'h5A, 1, 0, 0);
        chk("postrst_count", count_o, 1);
        chk("postrst_head", data_o, 8'h5A);
        exp_q.push_back(8'h5A);
        step(8'h5A, 1, 1, 0);
        chk("postrst_valid", valid_o, 0);
        chk("postrst_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/a0_change_fifo.md
A0_CHANGE_FIFO -- requirements
Module: a0_change_fifo

Interface
REQ-001 Parameter DW, default 8, width of the captured a0 value.
REQ-002 Parameter DEPTH, default 8, number of FIFO entries; SHALL be a power of two, 2 or greater.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 data_i  input  DW  CPU a0 output (data_out), sampled every cycle.
REQ-006 en_i  input  1  capture enable; when low, no pushes occur.
REQ-007 ready_i  input  1  downstream consumer accepts the head entry this cycle.
REQ-008 ovf_clr_i  input  1  synchronous clear of the overflow flag.
REQ-009 data_o  output  DW  head entry of the FIFO (first-word fall-through).
REQ-010 valid_o  output  1  FIFO non-empty; data_o is meaningful.
REQ-011 count_o  output  log2(DEPTH)+1  current number of stored entries.
REQ-012 overflow_o  output  1  sticky flag: one or more changes were dropped because the FIFO was full.

Function
REQ-013 Register prev_q SHALL load data_i on every clock edge, regardless of en_i.
REQ-014 A change event SHALL be defined as en_i=1 and data_i != prev_q in the same cycle.
REQ-015 A pop SHALL occur when valid_o=1 and ready_i=1 at a clock edge.
REQ-016 A push SHALL write data_i to the tail on the edge of a change event, if count < DEPTH or a pop occurs on the same edge.
REQ-017 valid_o SHALL assert one cycle after the first push into an empty FIFO (latency 1 edge), with data_o equal to the pushed value.
REQ-018 data_o SHALL be driven combinationally from the head entry; it SHALL hold its value while valid_o=1 and ready_i=0.
REQ-019 ready_i while valid_o=0 SHALL have no effect on pointers, count, or data.
REQ-020 Read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-021 count_o updates: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-022 A push and pop on the same edge with count=DEPTH SHALL both occur; count stays DEPTH and no overflow is flagged.
REQ-023 A push and pop on the same edge with count=1 SHALL leave count=1, with data_o equal to the new value next cycle.
REQ-024 A change event with count=DEPTH and no pop SHALL be dropped (FIFO contents unchanged) and SHALL set overflow_o on that edge.
REQ-025 overflow_o SHALL remain set until ovf_clr_i=1 or reset.
REQ-026 If ovf_clr_i=1 and a new drop occur on the same edge, overflow_o SHALL remain 1 (set wins).
REQ-027 Each cycle in which data_i differs from the previous cycle's data_i, with en_i high, SHALL produce exactly one entry; a held value SHALL produce no further entries.

Reset
REQ-028 On rst_i=1, without waiting for a clock edge, the following SHALL be cleared: read/write pointers and count_o to 0, valid_o to 0, overflow_o to 0, prev_q to 0.
REQ-029 Storage array contents need not reset; data_o is don't-care while valid_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries.
REQ-031 After rst_i deasserts, a nonzero data_i with en_i=1 SHALL be captured as a change on the first edge.

Verification
REQ-032 Reset, then data_i=0x00 held with en_i=1 -> valid_o=0, count_o=0 indefinitely.
REQ-033 en_i=1, ready_i=0; data_i sequence 0x05,0x05,0x09,0x09,0x02 on consecutive cycles -> count_o=3. Then ready_i=1 -> data_o pops 0x05, 0x09, 0x02, one per cycle, then valid_o=0.
REQ-034 DEPTH=8, ready_i=0, 10 distinct values 0x01..0x0A -> count_o=8 and overflow_o=1. Draining yields 0x01..0x08; ovf_clr_i pulse -> overflow_o=0.
REQ-035 Full FIFO, ready_i=1 and new value 0x7F on the same edge -> count_o stays 8, overflow_o stays 0, and 0x7F appears last on drain.
REQ-036 en_i=0 while data_i changes 0x11 to 0x22, then en_i=1 with 0x22 held -> no entries pushed.
REQ-037 Push 3 entries, assert rst_i between clock edges -> valid_o=0 and count_o=0 immediately; the first post-reset change pushes the correct value.
